// File: rtl/frs_queueing_message_queue.sv
// ============================================================================
//  Module   : frs_queueing_message_queue
//  Brief    : FRS Queueing capability register body with message FIFO and irq.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module frs_queueing_message_queue #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_frs_msg_valid,
  input  logic [15:0]   i_frs_msg_func_id,
  input  logic [3:0]    i_frs_msg_reason,
  input  logic [31:0]   i_hdr_data,
  input  logic [4:0]    i_int_msg_num,
  input  logic          i_cfg_rd,
  input  logic          i_cfg_wr,
  input  logic [1:0]    i_cfg_dw,
  input  logic [31:0]   i_cfg_wr_data,
  input  logic [3:0]    i_cfg_wr_be,
  output logic [31:0]   o_cfg_rd_data,
  output logic          o_cfg_rd_valid,
  output logic          o_frs_irq,
  output logic [CW-1:0] o_queue_count
);

  localparam int              c_PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PW-1:0] c_LAST    = c_PW'(DEPTH - 1);
  localparam logic [CW-1:0]   c_FULL    = CW'(DEPTH);
  localparam logic [11:0]     c_DEPTH12 = 12'(DEPTH);

  logic [15:0]     r_func   [DEPTH];
  logic [3:0]      r_reason [DEPTH];
  logic [c_PW-1:0] r_head;
  logic [c_PW-1:0] r_tail;
  logic [CW-1:0]   r_count;
  logic            r_rcv;
  logic            r_ovf;
  logic            r_ie;
  logic            r_irq;
  logic [31:0]     r_rd_data;
  logic            r_rd_valid;

  logic            w_empty;
  logic            w_full;
  logic            w_deq;
  logic            w_enq;
  logic            w_ovf_evt;
  logic            w_stat_wr;
  logic            w_rcv_nx;
  logic            w_ovf_nx;
  logic            w_ie_nx;
  logic            w_irq_nx;
  logic [31:0]     w_rd_mux;
  logic            w_unused;

  assign w_unused = &{1'b0, i_cfg_wr_data[31:17], i_cfg_wr_data[15:2],
                      i_cfg_wr_be[3], i_cfg_wr_be[1]};

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_FULL);
  // A dequeue frees a slot in the same cycle, so a full queue still accepts.
  assign w_deq     = i_cfg_wr && (i_cfg_dw == 2'd3) && !w_empty;
  assign w_enq     = i_frs_msg_valid && (!w_full || w_deq);
  assign w_ovf_evt = i_frs_msg_valid && w_full && !w_deq;
  assign w_stat_wr = i_cfg_wr && (i_cfg_dw == 2'd2);

  always_comb begin
    w_rcv_nx = r_rcv;
    w_ovf_nx = r_ovf;
    w_ie_nx  = r_ie;
    if (w_stat_wr && i_cfg_wr_be[0] && i_cfg_wr_data[0]) w_rcv_nx = 1'b0;
    if (w_stat_wr && i_cfg_wr_be[0] && i_cfg_wr_data[1]) w_ovf_nx = 1'b0;
    if (w_stat_wr && i_cfg_wr_be[2])                     w_ie_nx  = i_cfg_wr_data[16];
    if (w_enq)     w_rcv_nx = 1'b1;
    if (w_ovf_evt) w_ovf_nx = 1'b1;
    // Pulse only on rising status or rising enable, never on a held level.
    w_irq_nx = w_ie_nx && ((w_rcv_nx && !r_rcv) || (w_ovf_nx && !r_ovf) ||
                           (!r_ie && (w_rcv_nx || w_ovf_nx)));
  end

  always_comb begin
    w_rd_mux = '0;
    case (i_cfg_dw)
      2'd0: w_rd_mux = i_hdr_data;
      2'd1: w_rd_mux = {11'b0, i_int_msg_num, 4'b0, c_DEPTH12};
      2'd2: w_rd_mux = {15'b0, r_ie, 14'b0, r_ovf, r_rcv};
      default: begin
        if (!w_empty) w_rd_mux = {12'b0, r_reason[r_head], r_func[r_head]};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && w_enq) begin
      r_func[r_tail]   <= i_frs_msg_func_id;
      r_reason[r_tail] <= i_frs_msg_reason;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_rcv      <= 1'b0;
      r_ovf      <= 1'b0;
      r_ie       <= 1'b0;
      r_irq      <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_deq) r_head <= (r_head == c_LAST) ? '0 : r_head + c_PW'(1);
      if (w_enq) r_tail <= (r_tail == c_LAST) ? '0 : r_tail + c_PW'(1);
      if (w_enq && !w_deq)      r_count <= r_count + CW'(1);
      else if (w_deq && !w_enq) r_count <= r_count - CW'(1);
      r_rcv      <= w_rcv_nx;
      r_ovf      <= w_ovf_nx;
      r_ie       <= w_ie_nx;
      r_irq      <= w_irq_nx;
      r_rd_valid <= i_cfg_rd;
      if (i_cfg_rd) r_rd_data <= w_rd_mux;
    end
  end

  assign o_cfg_rd_data  = r_rd_data;
  assign o_cfg_rd_valid = r_rd_valid;
  assign o_frs_irq      = r_irq;
  assign o_queue_count  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_frs_queueing_message_queue.sv
// ============================================================================
//  Module   : tb_frs_queueing_message_queue
//  Brief    : Directed plus random bench against a queue-based reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_frs_queueing_message_queue;

  localparam int          c_DEPTH = 8;
  localparam int          c_CW    = $clog2(c_DEPTH + 1);
  localparam logic [4:0]  c_INTN  = 5'd5;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_frs_msg_valid;
  logic [15:0]     i_frs_msg_func_id;
  logic [3:0]      i_frs_msg_reason;
  logic [31:0]     i_hdr_data;
  logic [4:0]      i_int_msg_num;
  logic            i_cfg_rd;
  logic            i_cfg_wr;
  logic [1:0]      i_cfg_dw;
  logic [31:0]     i_cfg_wr_data;
  logic [3:0]      i_cfg_wr_be;
  logic [31:0]     o_cfg_rd_data;
  logic            o_cfg_rd_valid;
  logic            o_frs_irq;
  logic [c_CW-1:0] o_queue_count;

  frs_queueing_message_queue #(.DEPTH(c_DEPTH)) u_dut (
    .clk               (clk),
    .rst               (rst),
    .i_frs_msg_valid   (i_frs_msg_valid),
    .i_frs_msg_func_id (i_frs_msg_func_id),
    .i_frs_msg_reason  (i_frs_msg_reason),
    .i_hdr_data        (i_hdr_data),
    .i_int_msg_num     (i_int_msg_num),
    .i_cfg_rd          (i_cfg_rd),
    .i_cfg_wr          (i_cfg_wr),
    .i_cfg_dw          (i_cfg_dw),
    .i_cfg_wr_data     (i_cfg_wr_data),
    .i_cfg_wr_be       (i_cfg_wr_be),
    .o_cfg_rd_data     (o_cfg_rd_data),
    .o_cfg_rd_valid    (o_cfg_rd_valid),
    .o_frs_irq         (o_frs_irq),
    .o_queue_count     (o_queue_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: message queue plus status/control bits.
  logic [19:0] m_q [$];
  logic        m_rcv = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_ie  = 1'b0;
  logic [31:0] m_rd_data = '0;
  int          m_irq_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] dw);
    case (dw)
      2'd0:    return i_hdr_data;
      2'd1:    return {11'b0, c_INTN, 4'b0, 12'(c_DEPTH)};
      2'd2:    return {15'b0, m_ie, 14'b0, m_ovf, m_rcv};
      default: return (m_q.size() != 0) ? {12'b0, m_q[0]} : 32'h0;
    endcase
  endfunction

  task automatic step(input logic rs, input logic v, input logic [15:0] f,
                      input logic [3:0] r, input logic rd, input logic wr,
                      input logic [1:0] dw, input logic [31:0] wd, input logic [3:0] be);
    logic exp_irq, exp_rdv, deq, enq, ovf_evt, n_rcv, n_ovf, n_ie;
    rst = rs; i_frs_msg_valid = v; i_frs_msg_func_id = f; i_frs_msg_reason = r;
    i_cfg_rd = rd; i_cfg_wr = wr; i_cfg_dw = dw; i_cfg_wr_data = wd; i_cfg_wr_be = be;
    if (rs) begin
      m_q.delete();
      m_rcv = 1'b0; m_ovf = 1'b0; m_ie = 1'b0; m_rd_data = '0;
      exp_irq = 1'b0; exp_rdv = 1'b0;
    end else begin
      exp_rdv = rd;
      if (rd) m_rd_data = model_read(dw);
      deq     = wr && (dw == 2'd3) && (m_q.size() != 0);
      enq     = v && ((m_q.size() < c_DEPTH) || deq);
      ovf_evt = v && (m_q.size() == c_DEPTH) && !deq;
      if (deq) void'(m_q.pop_front());
      if (enq) m_q.push_back({r, f});
      n_rcv = (wr && dw == 2'd2 && be[0] && wd[0]) ? 1'b0 : m_rcv;
      n_ovf = (wr && dw == 2'd2 && be[0] && wd[1]) ? 1'b0 : m_ovf;
      n_ie  = (wr && dw == 2'd2 && be[2]) ? wd[16] : m_ie;
      if (enq)     n_rcv = 1'b1;
      if (ovf_evt) n_ovf = 1'b1;
      exp_irq = n_ie && ((n_rcv && !m_rcv) || (n_ovf && !m_ovf) ||
                         (!m_ie && (n_rcv || n_ovf)));
      m_rcv = n_rcv; m_ovf = n_ovf; m_ie = n_ie;
    end
    if (exp_irq) m_irq_total++;
    @(posedge clk);
    #1;
    check("rd_valid", 32'(o_cfg_rd_valid), 32'(exp_rdv));
    check("rd_data", o_cfg_rd_data, m_rd_data);
    check("irq", 32'(o_frs_irq), 32'(exp_irq));
    check("count", 32'(o_queue_count), 32'(m_q.size()));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
  endtask
  task automatic enq(input logic [15:0] f, input logic [3:0] r);
    step(1'b0, 1'b1, f, r, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
  endtask
  task automatic rd(input logic [1:0] dw);
    step(1'b0, 1'b0, 16'h0, 4'h0, 1'b1, 1'b0, dw, 32'h0, 4'h0);
  endtask
  task automatic wr(input logic [1:0] dw, input logic [31:0] d, input logic [3:0] be);
    step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1, dw, d, be);
  endtask
  task automatic do_reset();
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
  endtask

  initial begin
    int irq_before;
    i_hdr_data    = $urandom;
    i_int_msg_num = c_INTN;

    // 1: reset state and capability dword
    do_reset();
    rd(2'd1);
    check("dw1_const", o_cfg_rd_data, 32'h0005_0008);
    idle();
    check("rd_valid_pulse", 32'(o_cfg_rd_valid), 32'h0);
    rd(2'd0);

    // 2: single message round trip
    enq(16'h0100, 4'h2);
    rd(2'd3);
    check("dw3_head", o_cfg_rd_data, 32'h0002_0100);
    rd(2'd2);
    wr(2'd3, 32'h0, 4'h0);
    rd(2'd3);
    check("dw3_empty", o_cfg_rd_data, 32'h0);

    // 3: overflow leaves the oldest entry intact; RW1C clear via be[0]
    for (int i = 1; i <= 9; i++) enq(16'(i), 4'(i));
    check("count_full", 32'(o_queue_count), 32'd8);
    rd(2'd2);
    rd(2'd3);
    check("oldest_kept", o_cfg_rd_data, 32'h0001_0001);
    wr(2'd2, 32'h3, 4'h1);
    rd(2'd2);
    check("dw2_cleared", o_cfg_rd_data, 32'h0);

    // 4: full queue, enqueue and dequeue together
    step(1'b0, 1'b1, 16'hBEEF, 4'h7, 1'b0, 1'b1, 2'd3, 32'h0, 4'h0);
    rd(2'd2);
    for (int i = 0; i < 8; i++) begin
      rd(2'd3);
      wr(2'd3, $urandom, 4'($urandom));
    end
    wr(2'd3, 32'h0, 4'h0);

    // 5: interrupt edges
    do_reset();
    wr(2'd2, 32'h0001_0000, 4'h4);
    irq_before = m_irq_total;
    enq(16'h1234, 4'h1);
    enq(16'h5678, 4'h3);
    idle();
    check("irq_once", 32'(m_irq_total - irq_before), 32'd1);
    wr(2'd2, 32'h3, 4'h1);
    wr(2'd2, 32'h0, 4'h4);
    enq(16'h9ABC, 4'h4);
    wr(2'd2, 32'h0001_0000, 4'h4);
    wr(2'd2, 32'h0001_0003, 4'h2);
    idle();

    // 6: reset with queued messages, then dequeue while empty
    enq(16'h1111, 4'h1);
    enq(16'h2222, 4'h2);
    step(1'b1, 1'b1, 16'h3333, 4'h3, 1'b1, 1'b0, 2'd2, 32'h0, 4'h0);
    idle();
    wr(2'd3, 32'hFFFF_FFFF, 4'hF);
    rd(2'd3);
    rd(2'd2);

    // Random traffic with alternating fill/drain bias
    for (int i = 0; i < 4000; i++) begin
      int vpct;
      vpct = ((i / 400) % 2 == 0) ? 70 : 25;
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < vpct,
           16'($urandom), 4'($urandom),
           $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 35,
           2'($urandom),
           $urandom, 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
